control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_decoder.sv | 11 +
 rtl/control_unit.sv | 71 +++++++
 tb/tb_control_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: control FSM states and instruction class encodings shared by the control path.
package cpu_pkg;
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_ALU_WB = 4'd3,
    ST_ADR_HI = 4'd4,
    ST_ADR_LO = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_JMP    = 4'd8,
    ST_IMM    = 4'd9,
    ST_LD_WB  = 4'd10
  } state_t;
  // Non-ALU classes carry their ir[7:5] opcode as the encoding; any ir[7]=1 is ALU.
  typedef enum logic [2:0] {
    CLS_LDA = 3'b000,
    CLS_STA = 3'b001,
    CLS_JMP = 3'b010,
    CLS_LDI = 3'b011,
    CLS_ALU = 3'b100
  } instr_class_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational map from instruction byte 0 to its instruction class.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0]   ir,
  output instr_class_t cls
);
  logic unused_bits;
  assign unused_bits = ^ir[4:0];
  assign cls = ir[7] ? CLS_ALU : instr_class_t'(ir[7:5]);
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer driving the datapath strobes.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       jump_taken,
  output logic       cen_PC,
  output logic       ld_PC,
  output logic       ld_IR,
  output logic       ld_DI,
  output logic       ld_TR_12_8,
  output logic       ld_TR_7_0,
  output logic       ld_ALU,
  output logic       sel_ALU_src_reg1,
  output logic       sel_ALU_src_TR,
  output logic       ld_CZN,
  output logic       sel_CZN_src_RF,
  output logic       sel_CZN_src_ALU,
  output logic       sel_MEM_src_PC,
  output logic       sel_MEM_src_TR,
  output logic       mem_write,
  output logic       write_reg_en,
  output logic       sel_IR_3_2,
  output logic       sel_IR_4_3,
  output logic       sel_RF_write_src_TR_7_0,
  output logic       sel_writeSRC_reg1,
  output logic       sel_writeSRC_ALU
);
  state_t       state_q, state_d;
  instr_class_t cls;
  instr_decoder u_dec (.ir(ir), .cls(cls));
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = cls == CLS_ALU ? ST_EXEC : cls == CLS_LDI ? ST_IMM : ST_ADR_HI;
      ST_EXEC:   state_d = ST_ALU_WB;
      ST_ADR_HI: state_d = ST_ADR_LO;
      ST_ADR_LO: state_d = cls == CLS_STA ? ST_MEM_WR : cls == CLS_JMP ? ST_JMP : ST_MEM_RD;
      ST_MEM_RD: state_d = ST_LD_WB;
      ST_IMM:    state_d = ST_LD_WB;
      default:   state_d = ST_FETCH;
    endcase
  end
  // Reset gates the decode so FETCH strobes stay low while rst is held.
  always_comb begin
    {cen_PC, ld_PC, ld_IR, ld_DI, ld_TR_12_8, ld_TR_7_0, ld_ALU, sel_ALU_src_reg1,
     sel_ALU_src_TR, ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU, sel_MEM_src_PC,
     sel_MEM_src_TR, mem_write, write_reg_en, sel_IR_3_2, sel_IR_4_3,
     sel_RF_write_src_TR_7_0, sel_writeSRC_reg1, sel_writeSRC_ALU} = '0;
    if (!rst)
      case (state_q)
        ST_FETCH:  {sel_MEM_src_PC, ld_IR, ld_DI, cen_PC} = '1;
        ST_EXEC:   {sel_ALU_src_reg1, ld_ALU, ld_CZN, sel_CZN_src_ALU} = '1;
        ST_ALU_WB: {sel_IR_3_2, sel_writeSRC_ALU, write_reg_en} = '1;
        ST_ADR_HI: {sel_MEM_src_PC, ld_TR_12_8, cen_PC} = '1;
        ST_ADR_LO: {sel_MEM_src_PC, ld_TR_7_0, cen_PC} = '1;
        ST_MEM_RD: {sel_MEM_src_TR, ld_TR_7_0} = '1;
        ST_MEM_WR: {sel_MEM_src_TR, mem_write} = '1;
        ST_JMP:    ld_PC = jump_taken;
        ST_IMM:    {sel_MEM_src_PC, ld_TR_7_0, cen_PC} = '1;
        ST_LD_WB:  {sel_IR_4_3, sel_RF_write_src_TR_7_0, write_reg_en, ld_CZN, sel_CZN_src_RF} = '1;
        default:   ;
      endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven scoreboard bench for the control FSM plus reset/jump corner sequences.
module tb_control_unit;
  logic clk = 0, rst = 1, jump_taken = 0;
  logic [7:0] ir = 0;
  logic cen_PC, ld_PC, ld_IR, ld_DI, ld_TR_12_8, ld_TR_7_0, ld_ALU, sel_ALU_src_reg1,
        sel_ALU_src_TR, ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU, sel_MEM_src_PC,
        sel_MEM_src_TR, mem_write, write_reg_en, sel_IR_3_2, sel_IR_4_3,
        sel_RF_write_src_TR_7_0, sel_writeSRC_reg1, sel_writeSRC_ALU;
  int checks = 0, errors = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .jump_taken(jump_taken),
    .cen_PC(cen_PC), .ld_PC(ld_PC), .ld_IR(ld_IR), .ld_DI(ld_DI),
    .ld_TR_12_8(ld_TR_12_8), .ld_TR_7_0(ld_TR_7_0), .ld_ALU(ld_ALU),
    .sel_ALU_src_reg1(sel_ALU_src_reg1), .sel_ALU_src_TR(sel_ALU_src_TR),
    .ld_CZN(ld_CZN), .sel_CZN_src_RF(sel_CZN_src_RF), .sel_CZN_src_ALU(sel_CZN_src_ALU),
    .sel_MEM_src_PC(sel_MEM_src_PC), .sel_MEM_src_TR(sel_MEM_src_TR),
    .mem_write(mem_write), .write_reg_en(write_reg_en), .sel_IR_3_2(sel_IR_3_2),
    .sel_IR_4_3(sel_IR_4_3), .sel_RF_write_src_TR_7_0(sel_RF_write_src_TR_7_0),
    .sel_writeSRC_reg1(sel_writeSRC_reg1), .sel_writeSRC_ALU(sel_writeSRC_ALU)
  );

  always #5 clk = ~clk;

  logic [20:0] outs;
  assign outs = {cen_PC, ld_PC, ld_IR, ld_DI, ld_TR_12_8, ld_TR_7_0, ld_ALU, sel_ALU_src_reg1,
                 sel_ALU_src_TR, ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU, sel_MEM_src_PC,
                 sel_MEM_src_TR, mem_write, write_reg_en, sel_IR_3_2, sel_IR_4_3,
                 sel_RF_write_src_TR_7_0, sel_writeSRC_reg1, sel_writeSRC_ALU};

  localparam logic [20:0] B_CEN  = 21'd1 << 20, B_LDPC = 21'd1 << 19, B_IR   = 21'd1 << 18,
                          B_DI   = 21'd1 << 17, B_T12  = 21'd1 << 16, B_T70  = 21'd1 << 15,
                          B_ALU  = 21'd1 << 14, B_AR1  = 21'd1 << 13, B_CZN  = 21'd1 << 11,
                          B_CRF  = 21'd1 << 10, B_CAL  = 21'd1 << 9,  B_MPC  = 21'd1 << 8,
                          B_MTR  = 21'd1 << 7,  B_MW   = 21'd1 << 6,  B_WRE  = 21'd1 << 5,
                          B_I32  = 21'd1 << 4,  B_I43  = 21'd1 << 3,  B_RFT  = 21'd1 << 2,
                          B_WAL  = 21'd1 << 0;
  localparam logic [20:0] E_F  = B_MPC | B_IR | B_DI | B_CEN,
                          E_D  = 21'd0,
                          E_EX = B_AR1 | B_ALU | B_CZN | B_CAL,
                          E_AW = B_I32 | B_WAL | B_WRE,
                          E_AH = B_MPC | B_T12 | B_CEN,
                          E_AL = B_MPC | B_T70 | B_CEN,
                          E_MR = B_MTR | B_T70,
                          E_MW = B_MTR | B_MW,
                          E_JT = B_LDPC,
                          E_IM = B_MPC | B_T70 | B_CEN,
                          E_LW = B_I43 | B_RFT | B_WRE | B_CZN | B_CRF;

  typedef struct {
    logic [7:0]  ir;
    logic        jt;
    int          n;
    logic [20:0] seq [7];
  } vec_t;
  vec_t vecs [8];
  logic [20:0] sb [$];

  function automatic vec_t mk(input logic [7:0] i, input logic j, input int n,
                              input logic [20:0] s0, s1, s2, s3, s4, s5, s6);
    vec_t v;
    v.ir = i; v.jt = j; v.n = n;
    v.seq = '{s0, s1, s2, s3, s4, s5, s6};
    return v;
  endfunction

  task automatic check(input string name, input int cyc, input logic [20:0] got, input logic [20:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    if ((sel_ALU_src_reg1 & sel_ALU_src_TR) | (sel_CZN_src_RF & sel_CZN_src_ALU) |
        (sel_MEM_src_PC & sel_MEM_src_TR) | (sel_IR_3_2 & sel_IR_4_3) |
        (sel_RF_write_src_TR_7_0 + sel_writeSRC_reg1 + sel_writeSRC_ALU > 2'd1) |
        (cen_PC & ld_PC)) begin
      errors++;
      $display("FAIL select_pairs got %h want no overlap", outs);
    end
  end

  task automatic run_vec(input vec_t v);
    rst = 1; ir = v.ir; jump_taken = v.jt;
    @(negedge clk);
    check("reset_zero", 0, outs, 21'd0);
    for (int i = 0; i < v.n; i++) sb.push_back(v.seq[i]);
    rst = 0;
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) @(posedge clk);
      #1;
      check($sformatf("ir_%h_jt%0d", v.ir, v.jt), i + 1, outs, sb.pop_front());
    end
  endtask

  initial begin
    vecs[0] = mk(8'h9B, 0, 5, E_F, E_D, E_EX, E_AW, E_F, E_D, E_D);
    vecs[1] = mk(8'hE4, 1, 5, E_F, E_D, E_EX, E_AW, E_F, E_D, E_D);
    vecs[2] = mk(8'h6C, 0, 5, E_F, E_D, E_IM, E_LW, E_F, E_D, E_D);
    vecs[3] = mk(8'h7F, 1, 5, E_F, E_D, E_IM, E_LW, E_F, E_D, E_D);
    vecs[4] = mk(8'h08, 0, 7, E_F, E_D, E_AH, E_AL, E_MR, E_LW, E_F);
    vecs[5] = mk(8'h20, 0, 6, E_F, E_D, E_AH, E_AL, E_MW, E_F, E_D);
    vecs[6] = mk(8'h42, 1, 6, E_F, E_D, E_AH, E_AL, E_JT, E_F, E_D);
    vecs[7] = mk(8'h42, 0, 6, E_F, E_D, E_AH, E_AL, E_D, E_F, E_D);
    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Reset during MEM_RD of an LDA must abandon it with no LD_WB write.
    rst = 1; ir = 8'h08; jump_taken = 0;
    @(negedge clk);
    rst = 0;
    repeat (4) @(posedge clk);
    #1 check("lda_mem_rd", 5, outs, E_MR);
    #2 rst = 1;
    #1 check("lda_async_rst", 5, outs, 21'd0);
    @(posedge clk); #1 check("lda_rst_hold", 6, outs, 21'd0);
    @(negedge clk); rst = 0;
    #1 check("lda_rst_fetch", 1, outs, E_F);
    @(posedge clk); #1 check("lda_rst_decode", 2, outs, E_D);

    // ld_PC follows jump_taken combinationally inside JMP.
    rst = 1; ir = 8'h42; jump_taken = 0;
    @(negedge clk);
    rst = 0;
    repeat (4) @(posedge clk);
    #1 check("jmp_untaken", 5, outs, E_D);
    jump_taken = 1;
    #1 check("jmp_taken_live", 5, outs, E_JT);
    @(posedge clk); #1 check("jmp_next_fetch", 6, outs, E_F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
